// File: rtl/addsub_nibble_sched.sv
// Two-requester scheduler around one shared 4-bit add/subtract slice.
// Operands are processed nibble-serially, LSB first, with a registered carry between passes.
module addsub_nibble_sched #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req0_valid,
   output logic                   req0_ready,
   input  logic [4*NIBBLES-1:0]   req0_a,
   input  logic [4*NIBBLES-1:0]   req0_b,
   input  logic                   req0_sub,
   input  logic                   req1_valid,
   output logic                   req1_ready,
   input  logic [4*NIBBLES-1:0]   req1_a,
   input  logic [4*NIBBLES-1:0]   req1_b,
   input  logic                   req1_sub,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic                   rsp_id,
   output logic [4*NIBBLES-1:0]   rsp_sum,
   output logic                   rsp_cout,
   output logic                   rsp_ovf,
   output logic                   busy
);

   localparam int W  = 4 * NIBBLES;
   localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

   state_t          state_q, state_d;
   logic            ptr_q, ptr_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic            carry_q, carry_d;
   logic            id_q, id_d;
   logic [KW-1:0]   k_q, k_d;
   logic [W-1:0]    sum_q, sum_d;
   logic            cout_q, cout_d;
   logic            ovf_q, ovf_d;

   logic            grant0, grant1;
   logic [4:0]      nib;

   // Ties go to the requester that was not served last; ptr_q holds the last-served id.
   assign grant0 = req0_valid && (!req1_valid || ptr_q);
   assign grant1 = req1_valid && (!req0_valid || !ptr_q);

   assign req0_ready = (state_q == IDLE) && grant0;
   assign req1_ready = (state_q == IDLE) && grant1;

   assign rsp_valid = (state_q == RESP);
   assign busy      = (state_q != IDLE);
   assign rsp_id    = id_q;
   assign rsp_sum   = sum_q;
   assign rsp_cout  = cout_q;
   assign rsp_ovf   = ovf_q;

   assign nib = {1'b0, a_q[4*k_q +: 4]} + {1'b0, b_q[4*k_q +: 4]} + {4'b0, carry_q};

   always_comb begin
      // NOTE: every next-state value defaults to its current value first, so no path leaves one unassigned and infers a latch.
      state_d = state_q;
      ptr_d   = ptr_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      id_d    = id_q;
      k_d     = k_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      case (state_q)
         IDLE: begin
            if (req0_ready || req1_ready) begin
               // Subtraction is a + ~b + 1, the +1 entering as the initial carry.
               a_d     = req1_ready ? req1_a : req0_a;
               b_d     = req1_ready ? (req1_sub ? ~req1_b : req1_b)
                                    : (req0_sub ? ~req0_b : req0_b);
               carry_d = req1_ready ? req1_sub : req0_sub;
               id_d    = req1_ready;
               k_d     = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            sum_d[4*k_q +: 4] = nib[3:0];
            carry_d           = nib[4];
            k_d               = k_q + 1'b1;
            if (k_q == KW'(NIBBLES - 1)) begin
               cout_d  = nib[4];
               ovf_d   = (a_q[W-1] == b_q[W-1]) && (nib[3] != a_q[W-1]);
               state_d = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               ptr_d   = id_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: every register, datapath included, takes a reset value so outputs are defined the instant rst falls.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         ptr_q   <= 1'b1;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         id_q    <= 1'b0;
         k_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge values.
         state_q <= state_d;
         ptr_q   <= ptr_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         id_q    <= id_d;
         k_q     <= k_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

endmodule

// File: tb/tb_addsub_nibble_sched.sv
// Scoreboard bench for addsub_nibble_sched with NIBBLES = 4 (16-bit operands).
// Expected responses are queued at accept and compared when rsp_valid is seen.
module tb_addsub_nibble_sched;

   localparam int NIB = 4;
   localparam int W   = 4 * NIB;

   typedef struct packed {
      logic         id;
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } rsp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         req0_valid = 1'b0, req1_valid = 1'b0;
   logic         req0_ready, req1_ready;
   logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic         req0_sub = 1'b0, req1_sub = 1'b0;
   logic         rsp_valid, rsp_id, rsp_cout, rsp_ovf, busy;
   logic         rsp_ready = 1'b1;
   logic [W-1:0] rsp_sum;

   int   checks = 0;
   int   failures = 0;
   rsp_t exp_q[$];

   addsub_nibble_sched #(.NIBBLES(NIB)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
      .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic rsp_t model(input logic id, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      rsp_t       r;
      logic [W:0] full;
      if (sub) full = {1'b0, a} - {1'b0, b} + (1 << W);
      else     full = {1'b0, a} + {1'b0, b};
      r.id   = id;
      r.sum  = full[W-1:0];
      r.cout = full[W];
      if (sub) r.ovf = (a[W-1] != b[W-1]) && (full[W-1] != a[W-1]);
      else     r.ovf = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
      return r;
   endfunction

   function automatic rsp_t observed();
      rsp_t r;
      r.id = rsp_id; r.sum = rsp_sum; r.cout = rsp_cout; r.ovf = rsp_ovf;
      return r;
   endfunction

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send(input logic id, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, output bit ok);
      ok = 1'b0;
      if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sub = sub; end
      else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sub = sub; end
      #1;
      for (int i = 0; i < 50; i++) begin
         if ((id ? req1_ready : req0_ready) === 1'b1) begin ok = 1'b1; break; end
         @(negedge clk); #1;
      end
      if (ok) begin
         @(posedge clk);
         exp_q.push_back(model(id, a, b, sub));
         @(negedge clk);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   // Counts negedges until rsp_valid; returns at the negedge where it is first seen.
   task automatic wait_rsp(output rsp_t obs, output int lat, output bit ok);
      ok  = 1'b0;
      lat = 0;
      obs = '0;
      for (int i = 0; i < 50; i++) begin
         if (rsp_valid === 1'b1) begin ok = 1'b1; obs = observed(); break; end
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic finish_rsp();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #3;
      checks++;
      if ({rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf, busy} !== '0)
         begin failures++; $display("FAIL reset_outputs got valid=%b id=%b sum=%h cout=%b ovf=%b busy=%b want all 0", rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf, busy); end
      req0_valid = 1'b1;
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b10)
         begin failures++; $display("FAIL reset_ready got r0=%b r1=%b want 1 0", req0_ready, req1_ready); end
      req0_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_add();
      rsp_t obs, exp;
      int   lat;
      bit   ok;
      send(1'b0, 16'h1234, 16'h0FFF, 1'b0, ok);
      wait_rsp(obs, lat, ok);
      exp = exp_q.pop_front();
      checks++;
      if (!ok || obs !== exp)
         begin failures++; $display("FAIL add_result got %h want %h (ok=%0d)", obs, exp, ok); end
      checks++;
      if (lat !== NIB)
         begin failures++; $display("FAIL add_latency got %0d want %0d", lat, NIB); end
      checks++;
      if (obs.sum !== 16'h2233)
         begin failures++; $display("FAIL add_sum got %h want 2233", obs.sum); end
      finish_rsp();
   endtask

   task automatic test_arith(input string name, input logic id, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      rsp_t obs, exp;
      int   lat;
      bit   ok;
      send(id, a, b, sub, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL %s_accept got no ready want ready", name); return; end
      wait_rsp(obs, lat, ok);
      exp = exp_q.pop_front();
      checks++;
      if (!ok || obs !== exp || lat !== NIB)
         begin failures++; $display("FAIL %s got id=%b sum=%h cout=%b ovf=%b lat=%0d want id=%b sum=%h cout=%b ovf=%b lat=%0d",
                                    name, obs.id, obs.sum, obs.cout, obs.ovf, lat, exp.id, exp.sum, exp.cout, exp.ovf, NIB); end
      finish_rsp();
   endtask

   task automatic test_carry_sub();
      test_arith("carry_chain", 1'b1, 16'hFFFF, 16'h0001, 1'b0);
      test_arith("pos_ovf",     1'b1, 16'h7FFF, 16'h0001, 1'b0);
      test_arith("sub_borrow",  1'b0, 16'h0005, 16'h0007, 1'b1);
      test_arith("sub_ovf",     1'b1, 16'h8000, 16'h0001, 1'b1);
      for (int i = 0; i < 6; i++)
         test_arith("random", i[0], W'($urandom), W'($urandom), $urandom_range(0, 1) == 1);
   endtask

   task automatic test_arbitration();
      rsp_t obs, exp;
      int   grants;
      logic order[3];
      bit   both_seen;
      grants = 0;
      both_seen = 1'b0;
      rst = 1'b0;
      req0_a = 16'h1111; req0_b = 16'h2222; req0_sub = 1'b0;
      req1_a = 16'h9000; req1_b = 16'h1000; req1_sub = 1'b1;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      for (int cyc = 0; cyc < 80 && (grants < 3 || exp_q.size() > 0); cyc++) begin
         if (grants == 3) begin req0_valid = 1'b0; req1_valid = 1'b0; #1; end
         if (req0_ready === 1'b1 && req1_ready === 1'b1) both_seen = 1'b1;
         if (rsp_valid === 1'b1) begin
            obs = observed();
            exp = exp_q.pop_front();
            checks++;
            if (obs !== exp) begin failures++; $display("FAIL arb_result got %h want %h", obs, exp); end
         end
         if (grants < 3 && (req0_ready === 1'b1 || req1_ready === 1'b1)) begin
            order[grants] = req1_ready;
            exp_q.push_back(req1_ready ? model(1'b1, req1_a, req1_b, req1_sub) : model(1'b0, req0_a, req0_b, req0_sub));
            grants++;
         end
         @(negedge clk);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      checks++;
      if (grants != 3 || exp_q.size() != 0)
         begin failures++; $display("FAIL arb_count got grants=%0d pending=%0d want 3 0", grants, exp_q.size()); end
      checks++;
      if (grants == 3 && {order[0], order[1], order[2]} !== 3'b010)
         begin failures++; $display("FAIL arb_order got %b%b%b want 010", order[0], order[1], order[2]); end
      checks++;
      if (both_seen) begin failures++; $display("FAIL arb_exclusive got both readies high want never"); end
      exp_q.delete();
   endtask

   task automatic test_backpressure();
      rsp_t obs, exp;
      int   lat;
      bit   ok, bad;
      bad = 1'b0;
      rsp_ready = 1'b0;
      send(1'b1, 16'h0F0F, 16'h00F1, 1'b0, ok);
      wait_rsp(obs, lat, ok);
      exp = exp_q.pop_front();
      checks++;
      if (!ok || obs !== exp) begin failures++; $display("FAIL bp_result got %h want %h", obs, exp); end
      req0_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b1 || observed() !== obs || req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1) bad = 1'b1;
      end
      checks++;
      if (bad) begin failures++; $display("FAIL bp_hold got unstable/ready/idle during stall want held"); end
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || req0_ready !== 1'b1)
         begin failures++; $display("FAIL bp_release got valid=%b busy=%b r0=%b want 0 0 1", rsp_valid, busy, req0_ready); end
      req0_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_calc();
      rsp_t obs, exp;
      int   lat;
      bit   ok, stray;
      stray = 1'b0;
      send(1'b1, 16'hABCD, 16'h1234, 1'b0, ok);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf, busy} !== '0)
         begin failures++; $display("FAIL midreset_outputs got valid=%b id=%b sum=%h busy=%b want all 0", rsp_valid, rsp_id, rsp_sum, busy); end
      exp_q.delete();
      for (int i = 0; i < 3; i++) begin @(negedge clk); if (rsp_valid !== 1'b0) stray = 1'b1; end
      rst = 1'b1;
      for (int i = 0; i < 6; i++) begin @(negedge clk); if (rsp_valid !== 1'b0) stray = 1'b1; end
      checks++;
      if (stray) begin failures++; $display("FAIL midreset_stray got rsp_valid high want no response"); end
      req0_a = 16'h0101; req0_b = 16'h0202; req0_sub = 1'b1;
      req1_a = 16'h0303; req1_b = 16'h0404; req1_sub = 1'b0;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b10)
         begin failures++; $display("FAIL midreset_grant got r0=%b r1=%b want 1 0", req0_ready, req1_ready); end
      @(posedge clk);
      exp_q.push_back(model(1'b0, req0_a, req0_b, req0_sub));
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      wait_rsp(obs, lat, ok);
      exp = exp_q.pop_front();
      checks++;
      if (!ok || obs !== exp || lat !== NIB)
         begin failures++; $display("FAIL midreset_result got %h lat=%0d want %h lat=%0d", obs, lat, exp, NIB); end
      finish_rsp();
   endtask

   initial begin
      test_reset();
      test_add();
      test_carry_sub();
      test_arbitration();
      test_backpressure();
      test_reset_mid_calc();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
